prtc_host_xfer: RTL and testbench

- Initiator for the PRTC register protocol; drives the C033 (DATA) / C034 (CTL) register pair the CPU normally uses.
- Lets a non-CPU client (host PRAM save/restore, boot-time clock set) perform single-byte BRAM or clock-byte reads and writes via a req/ack handshake.
- Sits beside the CPU path, and its outputs are muxed onto the prtc register interface.
- Generates the exact command-byte sequences and single-cen strobe pulses the responder requires.

---
 rtl/prtc_host_xfer.sv | 183 ++++++++++++++++++
 tb/tb_prtc_host_xfer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prtc_host_xfer.sv
// rtl/prtc_host_xfer.sv - Non-CPU initiator for single-byte PRTC BRAM and clock-byte transfers
//
// Ports:
//   CLK_14M     in   system clock
//   reset_n     in   asynchronous active-low reset
//   cen         in   clock enable shared with the prtc; strobes only on cen=1
//   req         in   start request, sampled in IDLE only
//   op[1:0]     in   0=BRAM rd, 1=BRAM wr, 2=clock rd, 3=clock wr
//   index[7:0]  in   BRAM address, or clock byte number in [1:0]
//   wdata[7:0]  in   write data
//   busy        out  accept .. ack cycle inclusive
//   ack         out  one-cycle completion pulse
//   rdata[7:0]  out  read result, valid at ack, held until next read capture
//   rtc_addr    out  0=C033 (DATA), 1=C034 (CTL)
//   rtc_rw      out  1=read, 0=write
//   rtc_din     out  byte presented to the prtc
//   rtc_strobe  out  transaction strobe
//   rtc_dout    in   prtc registered read data

module prtc_host_xfer #(
    parameter int unsigned SETUP_CYCLES = 1
) (
    input  logic       CLK_14M,
    input  logic       reset_n,
    input  logic       cen,
    input  logic       req,
    input  logic [1:0] op,
    input  logic [7:0] index,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       rtc_addr,
    output logic       rtc_rw,
    output logic [7:0] rtc_din,
    output logic       rtc_strobe,
    input  logic [7:0] rtc_dout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W33,
        ST_SETUP,
        ST_WAIT,
        ST_R33A,
        ST_R33B,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [7:0] index_q, index_d;
    logic [7:0] wdata_q, wdata_d;
    // Segment of the command sequence: 0 = first command byte,
    // 1 = BRAM second address byte, 2 = data / final strobe.
    logic [1:0] seg_q, seg_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rdata_q, rdata_d;

    logic       is_rd;
    logic       is_bram;
    logic [7:0] ctl_byte;
    logic [7:0] seg_byte;
    logic [1:0] seg_next;

    assign is_rd    = ~op_q[0];
    assign is_bram  = ~op_q[1];
    assign ctl_byte = {1'b1, is_rd, 6'b000000};
    assign seg_next = (seg_q == 2'd0 && is_bram) ? 2'd1 : 2'd2;
    assign rdata    = rdata_q;

    always_comb begin
        seg_byte = wdata_q;
        case (seg_q)
            2'd0:    seg_byte = is_bram ? {is_rd, 4'b0111, index_q[7:5]}
                                        : {is_rd, 3'b000, index_q[1:0], 2'b01};
            2'd1:    seg_byte = {1'b0, index_q[4:0], 2'b00};
            default: seg_byte = wdata_q;
        endcase
    end

    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= 2'd0;
            index_q <= 8'd0;
            wdata_q <= 8'd0;
            seg_q   <= 2'd0;
            cnt_q   <= 4'd0;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            index_q <= index_d;
            wdata_q <= wdata_d;
            seg_q   <= seg_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        index_d    = index_q;
        wdata_d    = wdata_q;
        seg_d      = seg_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        busy       = (state_q != ST_IDLE);
        ack        = 1'b0;
        rtc_addr   = 1'b0;
        rtc_rw     = 1'b1;
        rtc_din    = 8'h00;
        rtc_strobe = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d    = op;
                    index_d = index;
                    wdata_d = wdata;
                    seg_d   = 2'd0;
                    state_d = ST_W33;
                end
            end
            ST_W33: begin
                rtc_rw  = 1'b0;
                rtc_din = seg_byte;
                cnt_d   = 4'd0;
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                rtc_addr = 1'b1;
                rtc_rw   = 1'b0;
                rtc_din  = ctl_byte;
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WAIT: begin
                rtc_addr = 1'b1;
                rtc_rw   = 1'b0;
                rtc_din  = ctl_byte;
                // Leaving this state on the strobe cycle guarantees one strobe per S34.
                if (cen) begin
                    rtc_strobe = 1'b1;
                    if (seg_q == 2'd2) begin
                        state_d = is_rd ? ST_R33A : ST_DONE;
                    end else begin
                        seg_d = seg_next;
                        // Reads have no data byte: the final CTL strobe follows directly.
                        if (seg_next == 2'd2 && is_rd) begin
                            cnt_d   = 4'd0;
                            state_d = ST_SETUP;
                        end else begin
                            state_d = ST_W33;
                        end
                    end
                end
            end
            ST_R33A: begin
                state_d = ST_R33B;
            end
            ST_R33B: begin
                rdata_d = rtc_dout;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                ack     = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prtc_host_xfer.sv
// tb/tb_prtc_host_xfer.sv - Directed self-checking bench for prtc_host_xfer

module tb_prtc_host_xfer;

    logic       CLK_14M = 1'b0;
    logic       reset_n = 1'b0;
    logic       cen = 1'b1;
    logic       req = 1'b0;
    logic       req3 = 1'b0;
    logic [1:0] op = 2'd0;
    logic [7:0] index = 8'd0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] rtc_dout;

    logic       busy, ack, rtc_addr, rtc_rw, rtc_strobe;
    logic [7:0] rdata, rtc_din;
    logic       busy3, ack3, rtc_addr3, rtc_rw3, rtc_strobe3;
    logic [7:0] rdata3, rtc_din3;

    int n_vec = 0;
    int n_mis = 0;

    prtc_host_xfer #(.SETUP_CYCLES(1)) dut (
        .CLK_14M(CLK_14M), .reset_n(reset_n), .cen(cen), .req(req), .op(op),
        .index(index), .wdata(wdata), .busy(busy), .ack(ack), .rdata(rdata),
        .rtc_addr(rtc_addr), .rtc_rw(rtc_rw), .rtc_din(rtc_din),
        .rtc_strobe(rtc_strobe), .rtc_dout(rtc_dout)
    );

    prtc_host_xfer #(.SETUP_CYCLES(3)) dut3 (
        .CLK_14M(CLK_14M), .reset_n(reset_n), .cen(cen), .req(req3), .op(op),
        .index(index), .wdata(wdata), .busy(busy3), .ack(ack3), .rdata(rdata3),
        .rtc_addr(rtc_addr3), .rtc_rw(rtc_rw3), .rtc_din(rtc_din3),
        .rtc_strobe(rtc_strobe3), .rtc_dout(rtc_dout)
    );

    initial forever #5 CLK_14M = ~CLK_14M;

    // Responder model for the SETUP_CYCLES=1 instance: decodes command bytes.
    logic [7:0] pram [256];
    logic [7:0] clkb [4];
    logic [7:0] st_data [64];
    logic [7:0] st_ctl [64];
    int         nstrobe = 0;
    int         bad_strobe = 0;
    int         mstate;
    logic [2:0] mhi;
    logic [7:0] maddr;
    logic       mclk;
    logic [7:0] dreg;
    logic       prev_strobe;

    initial begin
        for (int i = 0; i < 256; i++) pram[i] = 8'h00;
        pram[8'h5F] = 8'h81;
        clkb[0] = 8'h00; clkb[1] = 8'h00; clkb[2] = 8'h00; clkb[3] = 8'h06;
        rtc_dout = 8'h00;
        mstate = 0; mhi = 3'd0; maddr = 8'd0; mclk = 1'b0; dreg = 8'd0; prev_strobe = 1'b0;
        forever begin
            @(negedge CLK_14M);
            if (!reset_n) begin
                mstate = 0;
                dreg = 8'd0;
                prev_strobe = 1'b0;
            end else begin
                if (!rtc_addr && !rtc_rw) dreg = rtc_din;
                if (rtc_strobe) begin
                    if (!cen || prev_strobe) bad_strobe++;
                    st_data[nstrobe % 64] = dreg;
                    st_ctl[nstrobe % 64] = rtc_din;
                    nstrobe++;
                    case (mstate)
                        0: begin
                            if (dreg[6:3] == 4'b0111) begin
                                mhi = dreg[2:0];
                                mstate = 1;
                            end else if (dreg[6:4] == 3'b000 && dreg[1:0] == 2'b01) begin
                                mclk = 1'b1;
                                maddr = {6'd0, dreg[3:2]};
                                mstate = 2;
                            end
                        end
                        1: begin
                            mclk = 1'b0;
                            maddr = {mhi, dreg[6:2]};
                            mstate = 2;
                        end
                        default: begin
                            if (rtc_din[6]) rtc_dout = mclk ? clkb[maddr[1:0]] : pram[maddr];
                            else if (mclk) clkb[maddr[1:0]] = dreg;
                            else pram[maddr] = dreg;
                            mstate = 0;
                        end
                    endcase
                end
                prev_strobe = rtc_strobe;
            end
        end
    end

    // Stimulus helper: called at posedge+1 with the DUT idle.
    task automatic do_op(input logic [1:0] o, input logic [7:0] idx, input logic [7:0] wd,
                         input bit gated, output int ack_cyc, output logic [7:0] rd_ack,
                         output int busy_bad);
        op = o; index = idx; wdata = wd; req = 1'b1; cen = 1'b1;
        @(posedge CLK_14M); #1;
        req = 1'b0;
        ack_cyc = -1; rd_ack = 8'h00; busy_bad = 0;
        for (int c = 1; c <= 100; c++) begin
            cen = gated ? (c % 4 == 0) : 1'b1;
            if (!busy) busy_bad++;
            if (ack) begin
                ack_cyc = c;
                rd_ack = rdata;
                break;
            end
            @(posedge CLK_14M); #1;
        end
        @(posedge CLK_14M); #1;
        cen = 1'b1;
        if (busy || ack) busy_bad++;
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({busy, ack, rtc_addr, rtc_rw, rtc_strobe} !== 5'b00010) begin
            n_mis++; $display("FAIL reset_ctrl: got %b expected 00010", {busy, ack, rtc_addr, rtc_rw, rtc_strobe});
        end
        n_vec++;
        if ({rdata, rtc_din} !== 16'h0000) begin
            n_mis++; $display("FAIL reset_data: got %h expected 0000", {rdata, rtc_din});
        end
        n_vec++;
        if ({busy3, ack3, rtc_addr3, rtc_rw3, rtc_strobe3} !== 5'b00010) begin
            n_mis++; $display("FAIL reset_ctrl3: got %b expected 00010", {busy3, ack3, rtc_addr3, rtc_rw3, rtc_strobe3});
        end
        @(posedge CLK_14M); #1;
        reset_n = 1'b1;
        @(posedge CLK_14M); #1;
    endtask

    task automatic test_bram_write();
        int b, ac, bb, bs;
        logic [7:0] rd;
        b = nstrobe; bs = bad_strobe;
        do_op(2'd1, 8'hA5, 8'h3C, 1'b0, ac, rd, bb);
        n_vec++;
        if (ac !== 10) begin n_mis++; $display("FAIL bw_ack_cycle: got %0d expected 10", ac); end
        n_vec++;
        if (bb !== 0) begin n_mis++; $display("FAIL bw_busy: got %0d bad cycles expected 0", bb); end
        n_vec++;
        if (nstrobe - b !== 3) begin n_mis++; $display("FAIL bw_strobes: got %0d expected 3", nstrobe - b); end
        n_vec++;
        if ({st_data[b % 64], st_data[(b + 1) % 64], st_data[(b + 2) % 64]} !== 24'h3D143C) begin
            n_mis++; $display("FAIL bw_trace: got %h %h %h expected 3d 14 3c",
                              st_data[b % 64], st_data[(b + 1) % 64], st_data[(b + 2) % 64]);
        end
        n_vec++;
        if ({st_ctl[b % 64], st_ctl[(b + 1) % 64], st_ctl[(b + 2) % 64]} !== 24'h808080) begin
            n_mis++; $display("FAIL bw_ctl: got %h %h %h expected 80 80 80",
                              st_ctl[b % 64], st_ctl[(b + 1) % 64], st_ctl[(b + 2) % 64]);
        end
        n_vec++;
        if (pram[8'hA5] !== 8'h3C) begin n_mis++; $display("FAIL bw_pram: got %h expected 3c", pram[8'hA5]); end
        n_vec++;
        if (bad_strobe - bs !== 0) begin n_mis++; $display("FAIL bw_strobe_shape: got %0d expected 0", bad_strobe - bs); end
    endtask

    task automatic test_bram_read();
        int b, ac, bb;
        logic [7:0] rd;
        b = nstrobe;
        do_op(2'd0, 8'h5F, 8'h00, 1'b0, ac, rd, bb);
        n_vec++;
        if (ac !== 11) begin n_mis++; $display("FAIL br_ack_cycle: got %0d expected 11", ac); end
        n_vec++;
        if (rd !== 8'h81) begin n_mis++; $display("FAIL br_rdata: got %h expected 81", rd); end
        n_vec++;
        if ({st_data[b % 64], st_data[(b + 1) % 64]} !== 16'hBA7C) begin
            n_mis++; $display("FAIL br_cmd: got %h %h expected ba 7c", st_data[b % 64], st_data[(b + 1) % 64]);
        end
        n_vec++;
        if ({st_ctl[b % 64], st_ctl[(b + 1) % 64], st_ctl[(b + 2) % 64]} !== 24'hC0C0C0) begin
            n_mis++; $display("FAIL br_ctl: got %h %h %h expected c0 c0 c0",
                              st_ctl[b % 64], st_ctl[(b + 1) % 64], st_ctl[(b + 2) % 64]);
        end
        n_vec++;
        if (rdata !== 8'h81 || bb !== 0) begin
            n_mis++; $display("FAIL br_hold: got rdata %h busy_bad %0d expected 81 0", rdata, bb);
        end
    endtask

    task automatic test_clock();
        int b, ac, bb;
        logic [7:0] rd;
        b = nstrobe;
        do_op(2'd2, 8'h03, 8'h00, 1'b0, ac, rd, bb);
        n_vec++;
        if (ac !== 8 || rd !== 8'h06) begin n_mis++; $display("FAIL cr_result: got ack %0d rdata %h expected 8 06", ac, rd); end
        n_vec++;
        if (st_data[b % 64] !== 8'h8D || nstrobe - b !== 2) begin
            n_mis++; $display("FAIL cr_cmd: got %h strobes %0d expected 8d 2", st_data[b % 64], nstrobe - b);
        end
        b = nstrobe;
        do_op(2'd3, 8'hFC, 8'h55, 1'b0, ac, rd, bb);
        n_vec++;
        if (ac !== 7) begin n_mis++; $display("FAIL cw_ack_cycle: got %0d expected 7", ac); end
        n_vec++;
        if (st_data[b % 64] !== 8'h01 || clkb[0] !== 8'h55) begin
            n_mis++; $display("FAIL cw_effect: got cmd %h clk0 %h expected 01 55", st_data[b % 64], clkb[0]);
        end
        n_vec++;
        if (rdata !== 8'h06) begin n_mis++; $display("FAIL cw_rdata_kept: got %h expected 06", rdata); end
        do_op(2'd2, 8'h00, 8'h00, 1'b0, ac, rd, bb);
        n_vec++;
        if (ac !== 8 || rd !== 8'h55) begin n_mis++; $display("FAIL cr0_result: got ack %0d rdata %h expected 8 55", ac, rd); end
    endtask

    task automatic test_cen_gated();
        int ac, bb, bs;
        logic [7:0] rd;
        bs = bad_strobe;
        do_op(2'd1, 8'h42, 8'hC7, 1'b1, ac, rd, bb);
        n_vec++;
        if (ac !== 13) begin n_mis++; $display("FAIL gw_ack_cycle: got %0d expected 13", ac); end
        n_vec++;
        if (pram[8'h42] !== 8'hC7) begin n_mis++; $display("FAIL gw_pram: got %h expected c7", pram[8'h42]); end
        do_op(2'd0, 8'h42, 8'h00, 1'b1, ac, rd, bb);
        n_vec++;
        if (ac !== 15 || rd !== 8'hC7) begin n_mis++; $display("FAIL gr_result: got ack %0d rdata %h expected 15 c7", ac, rd); end
        n_vec++;
        if (bad_strobe - bs !== 0 || bb !== 0) begin
            n_mis++; $display("FAIL g_strobe_shape: got %0d bad strobes %0d busy errs expected 0 0", bad_strobe - bs, bb);
        end
    endtask

    task automatic test_abort();
        int b, ac, bb, hi_strobe;
        logic [7:0] rd;
        b = nstrobe;
        op = 2'd1; index = 8'h33; wdata = 8'h99; req = 1'b1; cen = 1'b1;
        @(posedge CLK_14M); #1;
        req = 1'b0;
        repeat (4) @(posedge CLK_14M);
        #1;
        n_vec++;
        if ({rtc_addr, rtc_strobe} !== 2'b10) begin n_mis++; $display("FAIL ab_in_setup: got %b expected 10", {rtc_addr, rtc_strobe}); end
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, ack, rtc_addr, rtc_rw, rtc_strobe, rdata, rtc_din} !== {5'b00010, 16'h0000}) begin
            n_mis++; $display("FAIL ab_async_reset: got %b %h %h expected 00010 00 00",
                              {busy, ack, rtc_addr, rtc_rw, rtc_strobe}, rdata, rtc_din);
        end
        hi_strobe = 0;
        repeat (3) begin
            @(posedge CLK_14M); #1;
            if (rtc_strobe || busy) hi_strobe++;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge CLK_14M); #1;
            if (rtc_strobe || busy || ack) hi_strobe++;
        end
        n_vec++;
        if (hi_strobe !== 0 || nstrobe - b !== 1 || pram[8'h33] !== 8'h00) begin
            n_mis++; $display("FAIL ab_no_strobe: got %0d activity %0d strobes pram %h expected 0 1 00",
                              hi_strobe, nstrobe - b, pram[8'h33]);
        end
        do_op(2'd2, 8'h03, 8'h00, 1'b0, ac, rd, bb);
        n_vec++;
        if (ac !== 8 || rd !== 8'h06 || bb !== 0) begin
            n_mis++; $display("FAIL ab_recover: got ack %0d rdata %h busy_bad %0d expected 8 06 0", ac, rd, bb);
        end
    endtask

    task automatic test_back_to_back();
        int s1, s2, setup_n, ac, after_bad;
        logic [7:0] din1, din6;
        s1 = -1; s2 = -1; setup_n = 0; ac = -1; after_bad = 0; din1 = 8'h00; din6 = 8'h00;
        op = 2'd3; index = 8'h01; wdata = 8'h77; req3 = 1'b1; cen = 1'b1;
        @(posedge CLK_14M); #1;
        req3 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) begin req3 = 1'b1; op = 2'd0; index = 8'hEE; wdata = 8'h11; end
            if (c == 10) req3 = 1'b0;
            if (c == 1) din1 = rtc_din3;
            if (c == 6) din6 = rtc_din3;
            if (rtc_addr3 && !rtc_strobe3) setup_n++;
            if (rtc_strobe3) begin
                if (s1 < 0) s1 = c; else if (s2 < 0) s2 = c;
            end
            if (ack3) begin ac = c; break; end
            @(posedge CLK_14M); #1;
        end
        repeat (4) begin
            @(posedge CLK_14M); #1;
            if (busy3 || ack3) after_bad++;
        end
        n_vec++;
        if (ac !== 11) begin n_mis++; $display("FAIL bb_ack_cycle: got %0d expected 11", ac); end
        n_vec++;
        if (s1 !== 5 || s2 !== 10 || setup_n !== 6) begin
            n_mis++; $display("FAIL bb_setup3: got strobes %0d %0d setup %0d expected 5 10 6", s1, s2, setup_n);
        end
        n_vec++;
        if (din1 !== 8'h05 || din6 !== 8'h77) begin
            n_mis++; $display("FAIL bb_latched: got %h %h expected 05 77", din1, din6);
        end
        n_vec++;
        if (after_bad !== 0) begin n_mis++; $display("FAIL bb_req_ignored: got %0d busy cycles expected 0", after_bad); end
    endtask

    initial begin
        test_reset();
        test_bram_write();
        test_bram_read();
        test_clock();
        test_cen_gated();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
